// File: rtl/line_buffer_bank.sv
// Vertical line buffer: TAPS-1 line memories that turn a raster pixel stream into a TAPS-tall column.
// Optional top-border replication: define LINE_BUF_BORDER_REPLICATE_EN.
module line_buffer_bank #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned LINE_BITS = 10,
   parameter int unsigned TAPS      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LINE_BITS-1:0]    line_len,
   input  logic                    sof,
   input  logic [WIDTH-1:0]        data_in,
   input  logic                    data_in_valid,
   output logic [TAPS*WIDTH-1:0]   data_out,
   output logic                    data_out_valid,
   output logic                    primed,
   output logic                    eol
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(TAPS);
   localparam int unsigned NL = TAPS - 1;

   logic [WIDTH-1:0]      mem [NL][DEPTH];
   logic [LINE_BITS-1:0]  col_q, len_q;
   logic [LW-1:0]         line_q;

   logic [LINE_BITS-1:0]  col_c, len_c, col_nxt;
   logic [LW-1:0]         line_c, line_nxt;
   logic [AW-1:0]         idx_c;
   logic                  last_c;
   logic [WIDTH-1:0]      tap_c [TAPS];
   logic [TAPS*WIDTH-1:0] column_c;

   // sof restarts the frame before this pixel is placed; line length is latched at column 0
   always_comb begin
      col_c  = sof ? '0 : col_q;
      line_c = sof ? '0 : line_q;
      len_c  = len_q;
      if (col_c == '0) begin
         if (line_len == '0 || 32'(line_len) > DEPTH)
            len_c = LINE_BITS'(DEPTH);
         else
            len_c = line_len;
      end
      idx_c    = col_c[AW-1:0];
      last_c   = (col_c == len_c - LINE_BITS'(1));
      col_nxt  = last_c ? '0 : col_c + LINE_BITS'(1);
      line_nxt = line_c;
      if (last_c && line_c != LW'(NL))
         line_nxt = line_c + LW'(1);
   end

   // Column assembly; tap 0 is the live pixel
   always_comb begin
      column_c = '0;
      tap_c[0] = data_in;
      for (int unsigned k = 1; k < TAPS; k++) begin
         tap_c[k] = mem[k-1][idx_c];
`ifdef LINE_BUF_BORDER_REPLICATE_EN
         if (32'(line_c) < k)
            tap_c[k] = tap_c[k-1];
`endif
      end
      for (int unsigned k = 0; k < TAPS; k++)
         column_c[k*WIDTH +: WIDTH] = tap_c[k];
   end

   // Line memories shift down one line per accepted pixel; contents are never cleared
   always_ff @(posedge clk) begin
      if (!reset && data_in_valid) begin
         mem[0][idx_c] <= data_in;
         for (int unsigned k = 1; k < NL; k++)
            mem[k][idx_c] <= mem[k-1][idx_c];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q          <= '0;
         len_q          <= '0;
         line_q         <= '0;
         primed         <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         eol            <= 1'b0;
      end else begin
         data_out_valid <= 1'b0;
         eol            <= 1'b0;
         if (data_in_valid) begin
            col_q    <= col_nxt;
            len_q    <= len_c;
            line_q   <= line_nxt;
            primed   <= (line_nxt == LW'(NL));
            data_out <= column_c;
            eol      <= last_c;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
            data_out_valid <= 1'b1;
`else
            data_out_valid <= (line_c == LW'(NL));
`endif
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_bank.sv
// Scoreboard bench for line_buffer_bank (TAPS=3, WIDTH=8, DEPTH=512).
module tb_line_buffer_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  line_len;
   logic        sof;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic [23:0] data_out;
   logic        data_out_valid;
   logic        primed;
   logic        eol;

   line_buffer_bank #(.WIDTH(8), .DEPTH(512), .LINE_BITS(10), .TAPS(3)) dut (
      .clk(clk), .reset(reset), .line_len(line_len), .sof(sof), .data_in(data_in),
      .data_in_valid(data_in_valid), .data_out(data_out), .data_out_valid(data_out_valid),
      .primed(primed), .eol(eol)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        e;
      logic        p;
      logic [23:0] d;
      logic        chk_d;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;

   // reference: frame pixels indexed by (line within frame, column)
   logic [7:0] fp [0:63][0:511];
   int         m_col = 0;
   int         m_line = 0;
   int         m_len = 512;

   task automatic drive(input string tag, input logic rst, input logic v, input logic s,
                        input logic [7:0] pix);
      exp_t e;
      e = '{v: 1'b0, e: 1'b0, p: 1'b0, d: 24'h0, chk_d: 1'b0};
      reset = rst; data_in_valid = v; sof = s; data_in = pix;
      if (rst) begin
         m_col = 0; m_line = 0;
         e.chk_d = 1'b1;
      end else if (v) begin
         if (s) begin m_col = 0; m_line = 0; end
         if (m_col == 0) m_len = (line_len == 0 || line_len > 512) ? 512 : int'(line_len);
         fp[m_line % 64][m_col] = pix;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
         e.v = 1'b1;
`else
         e.v = (m_line >= 2);
`endif
         if (e.v) begin
            for (int k = 0; k < 3; k++) begin
               int src;
               src = (k > m_line) ? m_line : m_line - k;
               e.d[k*8 +: 8] = fp[src % 64][m_col];
            end
         end
         e.chk_d = e.v;
         e.e = (m_col == m_len - 1);
         if (e.e) begin m_col = 0; m_line++; end
         else m_col++;
         e.p = (m_line >= 2);
      end else begin
         e.p = (m_line >= 2);
      end
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (data_out_valid !== e.v) begin
         errors++;
         $display("FAIL %s valid: got %b expected %b", tag, data_out_valid, e.v);
      end
      checks++;
      if (eol !== e.e) begin
         errors++;
         $display("FAIL %s eol: got %b expected %b", tag, eol, e.e);
      end
      checks++;
      if (primed !== e.p) begin
         errors++;
         $display("FAIL %s primed: got %b expected %b", tag, primed, e.p);
      end
      if (e.chk_d) begin
         checks++;
         if (data_out !== e.d) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", tag, data_out, e.d);
         end
      end
   endtask

   task automatic test_reset();
      line_len = 10'd4;
      drive("reset0", 1'b1, 1'b1, 1'b0, 8'hA5);
      drive("reset1", 1'b1, 1'b1, 1'b1, 8'h5A);
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 12; i++)
         drive("stream", 1'b0, 1'b1, i == 1, 8'(i));
      drive("stream_idle", 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_gaps();
      for (int i = 1; i <= 12; i++) begin
         drive("gaps", 1'b0, 1'b1, i == 1, 8'(i));
         drive("gaps_idle", 1'b0, 1'b0, 1'b1, 8'hFF);
      end
   endtask

   task automatic test_resof();
      for (int i = 1; i <= 22; i++)
         drive("resof", 1'b0, 1'b1, i == 1 || i == 11, 8'(i));
   endtask

   task automatic test_line_len();
      line_len = 10'd0;
      for (int i = 0; i < 512; i++)
         drive("len_depth", 1'b0, 1'b1, i == 0, 8'(i * 3));
      line_len = 10'd4;
      for (int i = 1; i <= 4; i++) begin
         if (i == 3) line_len = 10'd2;
         drive("len_change", 1'b0, 1'b1, 1'b0, 8'(100 + i));
      end
      for (int i = 1; i <= 6; i++)
         drive("len_two", 1'b0, 1'b1, 1'b0, 8'(200 + i));
      line_len = 10'd700;
      drive("len_over", 1'b0, 1'b1, 1'b1, 8'h11);
      drive("len_over", 1'b0, 1'b1, 1'b0, 8'h12);
   endtask

   task automatic test_reset_midline();
      line_len = 10'd4;
      for (int i = 1; i <= 6; i++)
         drive("mid_pre", 1'b0, 1'b1, i == 1, 8'(30 + i));
      drive("mid_reset", 1'b1, 1'b1, 1'b0, 8'hEE);
      for (int i = 1; i <= 13; i++)
         drive("mid_post", 1'b0, 1'b1, 1'b0, 8'(50 + i));
   endtask

   task automatic test_border();
      line_len = 10'd4;
      drive("border_sof", 1'b0, 1'b1, 1'b1, 8'd7);
      for (int i = 8; i <= 16; i++)
         drive("border", 1'b0, 1'b1, 1'b0, 8'(i));
   endtask

   task automatic test_back_to_back();
      line_len = 10'd3;
      for (int i = 0; i < 30; i++)
         drive("b2b", 1'b0, ($urandom_range(0, 3) != 0), (i == 0), 8'($urandom_range(0, 255)));
   endtask

   initial begin
      reset = 1'b1; sof = 1'b0; data_in = '0; data_in_valid = 1'b0; line_len = 10'd4;
      test_reset();
      test_stream();
      test_gaps();
      test_resof();
      test_line_len();
      test_reset_midline();
      test_border();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_buffer_bank.md
LINE_BUFFER_BANK -- requirements
Module: line_buffer_bank

Interface
REQ-001 Parameter WIDTH, default 8: pixel width in bits.
REQ-002 Parameter DEPTH, default 512: maximum line length in pixels.
REQ-003 Parameter LINE_BITS, default 10: width of the column pointer and line-length port; SHALL satisfy 2^LINE_BITS > DEPTH.
REQ-004 Parameter TAPS, default 3, range 2..8: vertical taps output; TAPS-1 lines stored.
REQ-005 One clock and one reset: reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 line_len  in  LINE_BITS  active line length in pixels; 0 means DEPTH.
REQ-009 sof  in  1  start of frame; qualified by data_in_valid.
REQ-010 data_in  in  WIDTH  input pixel.
REQ-011 data_in_valid  in  1  pixel accept strobe; no backpressure.
REQ-012 data_out  out  TAPS*WIDTH  vertical column; tap k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]; tap 0 = current pixel, tap k = same column k lines above.
REQ-013 data_out_valid  out  1  data_out holds a valid column.
REQ-014 primed  out  1  TAPS-1 complete lines stored.
REQ-015 eol  out  1  one-cycle pulse, aligned with data_out, marking the last column of a line.

Function
REQ-016 Accepted pixel: a pixel on a cycle with data_in_valid=1. Cycles with data_in_valid=0 SHALL change no state except that data_out_valid and eol deassert.
REQ-017 Latency: exactly 1 cycle; data_out, data_out_valid and eol SHALL be registered and reflect the pixel accepted on the previous cycle.
REQ-018 Storage: TAPS-1 line memories of DEPTH x WIDTH. An accepted pixel at column c SHALL:
  - read mem[k][c] as tap k+1;
  - write data_in into mem[0][c];
  - write the old mem[k-1][c] into mem[k][c].
REQ-019 Column pointer: advances on each accepted pixel; wraps to 0 after column L-1.
  - L = line_len, sampled when the column is 0.
  - line_len=0 or line_len>DEPTH SHALL give L=DEPTH.
  - line_len changes mid-line SHALL be ignored.
REQ-020 eol SHALL assert with the output of the pixel at column L-1.
REQ-021 Line counter: increments at each column-(L-1) pixel and saturates at TAPS-1; primed = (line counter == TAPS-1).
REQ-022 data_out_valid SHALL be 1 iff the previous cycle accepted a pixel while primed was 1, as evaluated before that pixel's own update.
REQ-023 sof with data_in_valid: the pixel SHALL be column 0 of a new frame; the column pointer and line counter SHALL clear first, so that pixel's output is not valid (without the macro) and primed drops on the next cycle.
REQ-024 sof without data_in_valid SHALL be ignored.
REQ-025 Memory contents are never cleared; stale data is masked by data_out_valid.

Reset
REQ-026 On reset, the following SHALL clear to 0 on the next clock edge: column pointer, line counter, primed, data_out, data_out_valid and eol.
REQ-027 Reset SHALL take priority over sof and data_in_valid in the same cycle.
REQ-028 Reset mid-line SHALL abandon the line; the next accepted pixel is column 0, line 0.

Configuration
REQ-029 Macro LINE_BUF_BORDER_REPLICATE_EN.
  - Defined: while the line counter is n < TAPS-1, taps k > n SHALL output tap n's value (top-border replication), and data_out_valid SHALL assert for every accepted pixel from the first line of the frame.
  - Undefined: taps output raw memory contents, and data_out_valid follows REQ-022.
  - primed and eol SHALL behave identically in both builds.

Verification (TAPS=3, WIDTH=8, line_len=4 unless stated)
REQ-030 Reset asserted for 2 cycles with data_in_valid=1 -> data_out=0, data_out_valid=0, primed=0, eol=0 throughout.
REQ-031 Continuous pixels 1..12, sof on pixel 1 -> primed=1 after pixel 8; pixel 9 output {tap2,tap1,tap0}={1,5,9} valid; pixel 12 output {4,8,12}; eol after pixels 4, 8 and 12.
REQ-032 Same stream with data_in_valid low on alternate cycles -> identical valid-output sequence; no output during gaps.
REQ-033 sof reasserted on pixel 11 of the stream -> primed=0 the next cycle; no valid output until 8 further pixels; the first subsequent valid output is {11,15,19}.
REQ-034 line_len=0 -> eol first after pixel 512 (DEPTH); line_len changed to 2 at pixel 3 -> no effect until the next column 0.
REQ-035 Macro defined, sof with pixel 7 -> next cycle data_out={7,7,7}, data_out_valid=1, primed=0.
